lsu_bus_ctrl: RTL
=================

# lsu_bus_ctrl

Load/store unit sitting directly downstream of the EX/MEM pipeline register, replacing the fixed-latency data memory hookup with a variable-latency request/acknowledge bus. It converts each MEM-stage load/store into one bus transaction with byte enables. It stalls the pipeline until the transaction completes, then aligns and sign/zero-extends load data for the MEM/WB register. Misaligned, illegal and timed-out accesses are reported instead of being issued or hanging the core.

## Interface
- DM_ADDRESS, 9, byte-address width of data memory
- DATA_W, 32, data width; fixed at 32
- TIMEOUT_CYC, 16, maximum BUSY cycles waiting for bus_ack before timeout fault; minimum 2
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- mem_read  in  1  EX/MEM load request
- mem_write  in  1  EX/MEM store request
- addr  in  DM_ADDRESS  byte address (EX/MEM ALU result)
- wr_data  in  DATA_W  store data, forwarded rs2 value
- func3  in  3  access size/sign
- ld_data  out  DATA_W  aligned, extended load result
- stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM; bubble into MEM/WB
- fault  out  1  one-cycle fault pulse
- fault_code  out  2  01 misaligned, 10 illegal func3 or read+write, 11 timeout
- bus_req  out  1  transaction request, held until ack
- bus_we  out  1  1 = write
- bus_addr  out  DM_ADDRESS  word-aligned address, addr with [1:0] forced to 0
- bus_be  out  4  byte enables
- bus_wdata  out  DATA_W  lane-replicated store data
- bus_ack  in  1  completion; bus_rdata valid in the same cycle for reads
- bus_rdata  in  DATA_W  read word

## Operation
- FSM states are IDLE, BUSY and DONE. All bus outputs are registered.
- IDLE behaviour:
  - On mem_read|mem_write with a legal, aligned access: stall=1 combinationally, latch we/addr/be/wdata/func3/addr[1:0], next state BUSY.
  - On an illegal or misaligned access: no request; fault=1 and fault_code set in the same cycle; stall=0; ld_data unchanged; stay IDLE.
  - With no access: stall=0.
- BUSY behaviour:
  - bus_req=1, stall=1, and all bus outputs stable.
  - On bus_ack, a read writes the aligned bus_rdata into ld_data, and the FSM moves to DONE.
  - The timeout counter counts BUSY cycles. If it reaches TIMEOUT_CYC with no ack, bus_req drops, fault is pulsed with code 11, ld_data is set to 0 for a read, and the FSM moves to DONE.
- DONE behaviour: stall=0 for exactly one cycle so the pipeline advances. The FSM always returns to IDLE and never re-issues on the still-present inputs.
- Legality:
  - Valid load func3 values: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Valid store func3 values: 000 SB, 001 SH, 010 SW.
  - Anything else, or mem_read&mem_write, is fault code 10.
  - Misalignment (fault code 01) is halfword with addr[0]=1, or word with addr[1:0]≠0.
- Store lanes:
  - SB: be=0001<<addr[1:0], wdata={4{wr_data[7:0]}}.
  - SH: be=0011<<addr[1:0], wdata={2{wr_data[15:0]}}.
  - SW: be=1111, wdata=wr_data.
- Reads drive be=1111.
- Load extraction:
  - Byte lane is addr[1:0]; halfword lane is addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend.
- ld_data holds its value until the next completed load. Stores and faults never modify it, except the timeout case above.

## Timing
- Reset values: FSM IDLE, bus_req=0, bus_we=0, bus_addr=0, bus_be=0, bus_wdata=0, ld_data=0, fault=0, fault_code=00, timeout counter 0.
- stall=0 during reset.
- bus_ack arriving in IDLE or DONE is ignored.
- Access timeline, with the access presented in cycle N:
  - N: IDLE, stall=1.
  - N+1: BUSY, bus_req=1. bus_ack is legal in this first BUSY cycle.
  - Cycle after ack: DONE, stall=0, ld_data valid.
- Minimum latency is 3 cycles per access, 2 of them stalled.
- Back-to-back accesses: the next access is seen in the IDLE cycle after DONE.
- Timeout: with bus_ack held 0, bus_req is high for exactly TIMEOUT_CYC cycles. The fault pulse occurs in the last BUSY cycle, and DONE follows.
- Reset mid-transaction: at the reset edge the FSM goes to IDLE and bus_req=0, with no fault.
- The timeout counter clears on entry to BUSY.

## Structure
- Package lsu_pkg holds:
  - state enum lsu_state_t {IDLE, BUSY, DONE};
  - func3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - fault code constants FLT_NONE, FLT_MISALIGN, FLT_ILLEGAL, FLT_TIMEOUT.
- Sub-module load_align is purely combinational: (rdata, func3, byte_off) -> extended 32-bit value. It is instantiated once, on bus_rdata.
- Datapath integration:
  - OR stall into Reg_Stall for the PC and IF/ID.
  - Hold ID/EX and EX/MEM on stall.
  - Zero MEM/WB RegWrite while stall=1.

## Test plan
- LW at addr 0x010, ack in first BUSY cycle, rdata 0xDEADBEEF -> bus_addr 0x010, be 1111, stall high for 2 cycles, ld_data 0xDEADBEEF in DONE.
- LB at 0x013, rdata 0x80FF_0000 -> ld_data 0xFFFFFF80. LBU at the same address -> 0x00000080. LHU at 0x012 -> 0x000080FF.
- SB at 0x005 with wr_data 0x000000A5 -> bus_we 1, bus_addr 0x004, be 0010, wdata 0xA5A5A5A5. SH at 0x006 -> be 1100.
- LW at 0x002 -> no bus_req, fault pulse with code 01, stall 0. Func3 011 load -> code 10. mem_read&mem_write -> code 10.
- bus_ack held 0 -> bus_req high 16 cycles, then fault code 11, DONE, ld_data 0, then IDLE.
- Reset asserted on the third BUSY cycle, with ack arriving one cycle later -> bus_req 0 after the reset edge, ack ignored, ld_data keeps its pre-reset value of 0, no fault.

Source files
------------

// File: rtl/lsu_bus_ctrl_pkg.sv
// Shared types and constants for the load/store bus controller: FSM states,
// func3 access encodings, fault codes and the access legality check.
package lsu_pkg;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} lsu_state_t;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [1:0] FLT_NONE     = 2'b00;
   localparam logic [1:0] FLT_MISALIGN = 2'b01;
   localparam logic [1:0] FLT_ILLEGAL  = 2'b10;
   localparam logic [1:0] FLT_TIMEOUT  = 2'b11;

   // Illegal encodings take priority over misalignment; func3[1:0] gives the size.
   function automatic logic [1:0] access_check(input logic       rd,
                                               input logic       wr,
                                               input logic [2:0] f3,
                                               input logic [1:0] off);
      logic legal;
      if (rd && wr) return FLT_ILLEGAL;
      legal = rd ? (f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU})
                 : (f3 inside {F3_B, F3_H, F3_W});
      if (!legal) return FLT_ILLEGAL;
      if (f3[1:0] == 2'b01 && off[0]) return FLT_MISALIGN;
      if (f3[1:0] == 2'b10 && off != 2'b00) return FLT_MISALIGN;
      return FLT_NONE;
   endfunction

endpackage

// File: rtl/lsu_bus_ctrl_load_align.sv
// Combinational load extraction: selects the byte/halfword lane of a bus word
// and sign- or zero-extends it according to func3.
module load_align
   import lsu_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [2:0]  func3,
   input  logic [1:0]  byte_off,
   output logic [31:0] value
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   always_comb begin
      byte_lane = rdata[8*byte_off +: 8];
      half_lane = byte_off[1] ? rdata[31:16] : rdata[15:0];
      case (func3)
         F3_B:    value = {{24{byte_lane[7]}}, byte_lane};
         F3_H:    value = {{16{half_lane[15]}}, half_lane};
         F3_BU:   value = {24'b0, byte_lane};
         F3_HU:   value = {16'b0, half_lane};
         default: value = rdata;
      endcase
   end

endmodule

// File: rtl/lsu_bus_ctrl.sv
// MEM-stage load/store unit: turns one load/store into a req/ack bus transaction,
// stalls the pipeline until it completes, and reports bad or timed-out accesses.
module lsu_bus_ctrl
   import lsu_pkg::*;
#(
   parameter int DM_ADDRESS  = 9,
   parameter int DATA_W      = 32,
   parameter int TIMEOUT_CYC = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  mem_read,
   input  logic                  mem_write,
   input  logic [DM_ADDRESS-1:0] addr,
   input  logic [DATA_W-1:0]     wr_data,
   input  logic [2:0]            func3,
   output logic [DATA_W-1:0]     ld_data,
   output logic                  stall,
   output logic                  fault,
   output logic [1:0]            fault_code,
   output logic                  bus_req,
   output logic                  bus_we,
   output logic [DM_ADDRESS-1:0] bus_addr,
   output logic [3:0]            bus_be,
   output logic [DATA_W-1:0]     bus_wdata,
   input  logic                  bus_ack,
   input  logic [DATA_W-1:0]     bus_rdata
);

   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

   lsu_state_t        state, state_next;
   logic [CNT_W-1:0]  tmo_cnt;
   logic [2:0]        f3_q;
   logic [1:0]        off_q;
   logic              access, start, timeout;
   logic [1:0]        chk;
   logic [3:0]        be_next;
   logic [DATA_W-1:0] wdata_next;
   logic [DATA_W-1:0] aligned;

   load_align u_load_align (
      .rdata    (bus_rdata),
      .func3    (f3_q),
      .byte_off (off_q),
      .value    (aligned)
   );

   // The counter holds the number of BUSY cycles already completed, so the
   // TIMEOUT_CYC-th BUSY cycle is the one where it equals TIMEOUT_CYC-1.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      state_next = state;
      stall      = 1'b0;
      fault      = 1'b0;
      fault_code = FLT_NONE;
      start      = 1'b0;
      access     = mem_read | mem_write;
      chk        = access_check(mem_read, mem_write, func3, addr[1:0]);
      timeout    = (tmo_cnt == CNT_W'(TIMEOUT_CYC - 1)) && !bus_ack;
      case (state)
         IDLE: begin
            if (access) begin
               if (chk == FLT_NONE) begin
                  stall      = 1'b1;
                  start      = 1'b1;
                  state_next = BUSY;
               end else begin
                  fault      = 1'b1;
                  fault_code = chk;
               end
            end
         end
         BUSY: begin
            stall = 1'b1;
            if (bus_ack) begin
               state_next = DONE;
            end else if (timeout) begin
               fault      = 1'b1;
               fault_code = FLT_TIMEOUT;
               state_next = DONE;
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
      if (reset) begin
         stall      = 1'b0;
         fault      = 1'b0;
         fault_code = FLT_NONE;
      end
   end

   always_comb begin
      case (func3[1:0])
         2'b00: begin
            be_next    = 4'b0001 << addr[1:0];
            wdata_next = {4{wr_data[7:0]}};
         end
         2'b01: begin
            be_next    = 4'b0011 << addr[1:0];
            wdata_next = {2{wr_data[15:0]}};
         end
         default: begin
            be_next    = 4'b1111;
            wdata_next = wr_data;
         end
      endcase
      if (!mem_write) be_next = 4'b1111;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         bus_req   <= 1'b0;
         bus_we    <= 1'b0;
         bus_addr  <= '0;
         bus_be    <= '0;
         bus_wdata <= '0;
         ld_data   <= '0;
         f3_q      <= '0;
         off_q     <= '0;
         tmo_cnt   <= '0;
      end else begin
         state <= state_next;
         if (start) begin
            bus_req   <= 1'b1;
            bus_we    <= mem_write;
            bus_addr  <= {addr[DM_ADDRESS-1:2], 2'b00};
            bus_be    <= be_next;
            bus_wdata <= wdata_next;
            f3_q      <= func3;
            off_q     <= addr[1:0];
            tmo_cnt   <= '0;
         end else if (state == BUSY) begin
            tmo_cnt <= tmo_cnt + 1'b1;
            if (bus_ack || timeout) bus_req <= 1'b0;
            if (bus_ack && !bus_we) ld_data <= aligned;
            else if (timeout && !bus_we) ld_data <= '0;
         end
      end
   end

endmodule
